// File: rtl/agreement_checker.sv
// Dual-channel agreement checker: compares redundant A/B words, confirms agreement after a
// run of matching pairs, latches a fault after a run of mismatches, hands results downstream.
module agreement_checker #(
  parameter int          WIDTH       = 16,
  parameter int          TOL         = 0,
  parameter int          CONFIRM     = 3,
  parameter int          FAULT_LIMIT = 4,
  parameter logic [15:0] TOTAL_INIT  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_agree,
  output logic             fault,
  input  logic             clear_fault,
  output logic [15:0]      mismatch_total
);

  localparam int AW = $clog2(CONFIRM + 1);
  localparam int MW = $clog2(FAULT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, CMP, OUT, FAULT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] last_good_q, last_good_d;
  logic             agree_q, agree_d;
  logic [AW-1:0]    agree_cnt_q, agree_cnt_d;
  logic [MW-1:0]    mis_cnt_q, mis_cnt_d;
  logic [15:0]      total_q, total_d;

  // One extra bit keeps the magnitude exact: 0x0000 vs 0xFFFF is far apart, not 1 apart.
  logic [WIDTH:0] diff;
  logic           match;

  always_comb begin
    if (a_q >= b_q) diff = {1'b0, a_q} - {1'b0, b_q};
    else            diff = {1'b0, b_q} - {1'b0, a_q};
    match = (diff <= (WIDTH+1)'(TOL));
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    last_good_d = last_good_q;
    agree_d     = agree_q;
    agree_cnt_d = agree_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    total_d     = total_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = CMP;
        end
      end
      CMP: begin
        if (match) begin
          if (agree_cnt_q != AW'(CONFIRM)) agree_cnt_d = agree_cnt_q + AW'(1);
          mis_cnt_d   = '0;
          last_good_d = a_q;
          data_d      = a_q;
          agree_d     = (agree_cnt_d == AW'(CONFIRM));
          state_d     = OUT;
        end else begin
          agree_cnt_d = '0;
          mis_cnt_d   = mis_cnt_q + MW'(1);
          if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
          data_d      = last_good_q;
          agree_d     = 1'b0;
          // The mismatch that completes the run produces no result.
          state_d     = (mis_cnt_d == MW'(FAULT_LIMIT)) ? FAULT : OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      FAULT: begin
        if (clear_fault) begin
          agree_cnt_d = '0;
          mis_cnt_d   = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      last_good_q <= '0;
      agree_q     <= 1'b0;
      agree_cnt_q <= '0;
      mis_cnt_q   <= '0;
      total_q     <= TOTAL_INIT;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      last_good_q <= last_good_d;
      agree_q     <= agree_d;
      agree_cnt_q <= agree_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      total_q     <= total_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == OUT);
  assign fault          = (state_q == FAULT);
  assign out_data       = data_q;
  assign out_agree      = agree_q;
  assign mismatch_total = total_q;

endmodule

// File: tb/tb_agreement_checker.sv
// Bench for agreement_checker: table-driven pairs scored through an expected-result queue,
// plus hand-written backpressure, reset, fault and width-edge sequences.
module tb_agreement_checker;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        expOut;
    logic [15:0] expData;
    logic        expAgree;
    logic [15:0] expTotal;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        agree;
    logic [15:0] total;
  } exp_t;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid, inReady, outValid, outReady, outAgree, fault, clearFault;
  logic [15:0] inA, inB, outData, mismatchTotal;

  logic        inValid2, inReady2, outValid2, outReady2, outAgree2, fault2, clearFault2;
  logic [15:0] inA2, inB2, outData2, mismatchTotal2;

  exp_t expQ[$];
  vec_t vecs[NV];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  agreement_checker #(.WIDTH(16), .TOL(0), .CONFIRM(3), .FAULT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_a(inA), .in_b(inB),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_agree(outAgree),
    .fault(fault), .clear_fault(clearFault), .mismatch_total(mismatchTotal)
  );

  // Second instance: tolerance of 1 and a mismatch counter preloaded just below saturation.
  agreement_checker #(.WIDTH(16), .TOL(1), .CONFIRM(3), .FAULT_LIMIT(4),
                      .TOTAL_INIT(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(inValid2), .in_ready(inReady2), .in_a(inA2), .in_b(inB2),
    .out_valid(outValid2), .out_ready(outReady2), .out_data(outData2), .out_agree(outAgree2),
    .fault(fault2), .clear_fault(clearFault2), .mismatch_total(mismatchTotal2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [15:0] data, input logic agree, input logic [15:0] total);
    exp_t e;
    e.data  = data;
    e.agree = agree;
    e.total = total;
    expQ.push_back(e);
  endtask

  // Waits (bounded) for in_ready, then presents the pair for exactly one accepting edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!inReady && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inReady) begin
      checks++;
      failures++;
      $display("[TB] FAIL in_ready_timeout: in_ready stayed 0");
      return;
    end
    inA = a; inB = b; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("queue_drained", expQ.size(), 0);
  endtask

  task automatic runDut2(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] expData, input logic expAgree,
                         input logic [15:0] expTotal);
    int n = 0;
    inA2 = a; inB2 = b; inValid2 = 1'b1;
    @(posedge clk); #1;
    inValid2 = 1'b0;
    while (!outValid2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w_out_valid", outValid2, 1);
    checkOutput("w_out_data", outData2, expData);
    checkOutput("w_out_agree", outAgree2, expAgree);
    checkOutput("w_mismatch_total", mismatchTotal2, expTotal);
    @(posedge clk); #1;
  endtask

  // Scoreboard: a handshake seen here completes on the following rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && outValid && outReady) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out: data 0x%0h with nothing expected", outData);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_data", outData, e.data);
        checkOutput("out_agree", outAgree, e.agree);
        checkOutput("mismatch_total", mismatchTotal, e.total);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{16'h1234, 16'h1234, 1'b1, 16'h1234, 1'b0, 16'd0};
    vecs[1]  = '{16'h1234, 16'h1234, 1'b1, 16'h1234, 1'b0, 16'd0};
    vecs[2]  = '{16'h1234, 16'h1234, 1'b1, 16'h1234, 1'b1, 16'd0};
    vecs[3]  = '{16'h1234, 16'h1235, 1'b1, 16'h1234, 1'b0, 16'd1};
    vecs[4]  = '{16'h4444, 16'h4444, 1'b1, 16'h4444, 1'b0, 16'd1};
    vecs[5]  = '{16'h0001, 16'h0002, 1'b1, 16'h4444, 1'b0, 16'd2};
    vecs[6]  = '{16'h0001, 16'h0002, 1'b1, 16'h4444, 1'b0, 16'd3};
    vecs[7]  = '{16'h0001, 16'h0002, 1'b1, 16'h4444, 1'b0, 16'd4};
    vecs[8]  = '{16'h0001, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'd5};
    vecs[9]  = '{16'h7777, 16'h7777, 1'b1, 16'h7777, 1'b0, 16'd5};
    vecs[10] = '{16'h0001, 16'h0003, 1'b1, 16'h7777, 1'b0, 16'd6};
    vecs[11] = '{16'h7777, 16'h7777, 1'b1, 16'h7777, 1'b0, 16'd6};

    rst = 1'b1;
    inValid = 1'b0; inA = '0; inB = '0; outReady = 1'b1; clearFault = 1'b0;
    inValid2 = 1'b0; inA2 = '0; inB2 = '0; outReady2 = 1'b1; clearFault2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_out_data", outData, 0);
    checkOutput("rst_out_agree", outAgree, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_in_ready", inReady, 1);
    checkOutput("rst_mismatch_total", mismatchTotal, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].expOut) pushExp(vecs[i].expData, vecs[i].expAgree, vecs[i].expTotal);
      applyStimulus(vecs[i].a, vecs[i].b);
      if (!vecs[i].expOut) begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("fault_set", fault, 1);
        checkOutput("fault_in_ready", inReady, 0);
        checkOutput("fault_out_valid", outValid, 0);
        checkOutput("fault_total", mismatchTotal, vecs[i].expTotal);
        clearFault = 1'b1;
        @(posedge clk); #1;
        clearFault = 1'b0;
        checkOutput("clear_fault", fault, 0);
        checkOutput("clear_in_ready", inReady, 1);
        checkOutput("clear_total", mismatchTotal, vecs[i].expTotal);
      end
    end
    waitDrain();

    // Latency and backpressure.
    outReady = 1'b0;
    pushExp(16'h5555, 1'b0, 16'd6);
    applyStimulus(16'h5555, 16'h5555);
    checkOutput("lat_cmp_valid", outValid, 0);
    @(posedge clk); #1;
    checkOutput("lat_out_valid", outValid, 1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_out_valid", outValid, 1);
      checkOutput("bp_out_data", outData, 16'h5555);
      checkOutput("bp_out_agree", outAgree, 0);
      checkOutput("bp_in_ready", inReady, 0);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready", inReady, 1);
    checkOutput("bp_release_out_valid", outValid, 0);
    waitDrain();

    // Reset while a result is waiting for the consumer.
    outReady = 1'b0;
    applyStimulus(16'h6666, 16'h6666);
    @(posedge clk); #1;
    checkOutput("midrst_pre_valid", outValid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_out_valid", outValid, 0);
    checkOutput("midrst_in_ready", inReady, 1);
    checkOutput("midrst_out_data", outData, 0);
    checkOutput("midrst_total", mismatchTotal, 0);
    checkOutput("midrst_fault", fault, 0);
    outReady = 1'b1;
    pushExp(16'h1234, 1'b0, 16'd0);
    applyStimulus(16'h1234, 16'h1234);
    waitDrain();

    // Width edges and counter saturation on the tolerant instance.
    runDut2(16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF);
    runDut2(16'hFFFF, 16'hFFFE, 16'hFFFF, 1'b0, 16'hFFFF);
    runDut2(16'h0010, 16'h0020, 16'hFFFF, 1'b0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
